// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream multiplexer with a registered output stage.
// Channel choice is either an external select (MODE 0) or round-robin (MODE 1).
module stream_mux_rr #(
   parameter int WIDTH = 8,
   parameter int N     = 4,
   parameter int MODE  = 0,
   localparam int SW   = (N > 1) ? $clog2(N) : 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [N*WIDTH-1:0] in_data,
   input  logic [N-1:0]       in_valid,
   output logic [N-1:0]       in_ready,
   input  logic [SW-1:0]      sel,
   output logic [WIDTH-1:0]   out_data,
   output logic               out_valid,
   output logic [SW-1:0]      out_ch,
   input  logic               out_ready
);

   // Handshake: a word moves on a channel in any cycle where that channel's
   // valid and ready are both 1 at the rising edge; a source holding valid=1
   // keeps its data stable until accepted, and ready never depends on data.

   logic             load_ok;
   logic             grant_vld;
   logic [SW-1:0]    grant;
   logic [SW-1:0]    ptr;
   logic [WIDTH-1:0] g_data;
   logic             xfer;

   assign load_ok = !out_valid || out_ready;
   assign xfer    = grant_vld && load_ok;

   always_comb begin
      grant     = '0;
      grant_vld = 1'b0;
      if (MODE == 0) begin
         for (int i = 0; i < N; i++) begin
            if (in_valid[i] && (sel == SW'(i))) begin
               grant     = SW'(i);
               grant_vld = 1'b1;
            end
         end
      end else begin
         // Two descending passes: the second (channels above ptr) overrides the
         // first, so the lowest valid index after ptr wins, else the wrap-around.
         for (int i = N - 1; i >= 0; i--) begin
            if (in_valid[i] && (SW'(i) <= ptr)) begin
               grant     = SW'(i);
               grant_vld = 1'b1;
            end
         end
         for (int i = N - 1; i >= 0; i--) begin
            if (in_valid[i] && (SW'(i) > ptr)) begin
               grant     = SW'(i);
               grant_vld = 1'b1;
            end
         end
      end
   end

   always_comb begin
      in_ready = '0;
      g_data   = '0;
      for (int i = 0; i < N; i++) begin
         if (grant == SW'(i)) begin
            in_ready[i] = load_ok && grant_vld;
            g_data      = in_data[i*WIDTH +: WIDTH];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_ch    <= '0;
         ptr       <= SW'(N - 1);
      end else begin
         if (xfer) begin
            out_data  <= g_data;
            out_ch    <= grant;
            out_valid <= 1'b1;
            if (MODE == 1) ptr <= grant;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Bench for stream_mux_rr: directed vector table on a 4x8 round-robin instance,
// hand sequences for fixed select and mid-stream reset, and a randomised sweep.
module tb_stream_mux_rr;

   logic clk;
   logic rst_n;
   int   n_vec = 0;
   int   n_err = 0;

   // Round-robin, N=4, WIDTH=8
   logic [31:0] rr_data;
   logic [3:0]  rr_valid, rr_ready;
   logic [1:0]  rr_sel, rr_och;
   logic [7:0]  rr_odata;
   logic        rr_ovalid, rr_oready;
   // Fixed select, N=4, WIDTH=8
   logic [31:0] fx_data;
   logic [3:0]  fx_valid, fx_ready;
   logic [1:0]  fx_sel, fx_och;
   logic [7:0]  fx_odata;
   logic        fx_ovalid, fx_oready;
   // Round-robin, N=2, WIDTH=32
   logic [63:0] a_data;
   logic [1:0]  a_valid, a_ready;
   logic [0:0]  a_sel, a_och;
   logic [31:0] a_odata;
   logic        a_ovalid, a_oready;
   // Round-robin, N=16, WIDTH=1
   logic [15:0] b_data, b_valid, b_ready;
   logic [3:0]  b_sel, b_och;
   logic [0:0]  b_odata;
   logic        b_ovalid, b_oready;

   stream_mux_rr #(.WIDTH(8), .N(4), .MODE(1)) u_rr (
      .clk(clk), .rst_n(rst_n), .in_data(rr_data), .in_valid(rr_valid), .in_ready(rr_ready),
      .sel(rr_sel), .out_data(rr_odata), .out_valid(rr_ovalid), .out_ch(rr_och), .out_ready(rr_oready));
   stream_mux_rr #(.WIDTH(8), .N(4), .MODE(0)) u_fx (
      .clk(clk), .rst_n(rst_n), .in_data(fx_data), .in_valid(fx_valid), .in_ready(fx_ready),
      .sel(fx_sel), .out_data(fx_odata), .out_valid(fx_ovalid), .out_ch(fx_och), .out_ready(fx_oready));
   stream_mux_rr #(.WIDTH(32), .N(2), .MODE(1)) u_n2 (
      .clk(clk), .rst_n(rst_n), .in_data(a_data), .in_valid(a_valid), .in_ready(a_ready),
      .sel(a_sel), .out_data(a_odata), .out_valid(a_ovalid), .out_ch(a_och), .out_ready(a_oready));
   stream_mux_rr #(.WIDTH(1), .N(16), .MODE(1)) u_n16 (
      .clk(clk), .rst_n(rst_n), .in_data(b_data), .in_valid(b_valid), .in_ready(b_ready),
      .sel(b_sel), .out_data(b_odata), .out_valid(b_ovalid), .out_ch(b_och), .out_ready(b_oready));

   // Clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] valid;
      logic       oready;
      logic [3:0] exp_ready;
      logic       exp_ovalid;
      logic [7:0] exp_odata;
      logic [1:0] exp_och;
   } vec_t;
   vec_t vecs[24];

   // Scoreboard for the sweep: one expected queue per channel
   logic [31:0] a_q[2][$];
   logic [0:0]  b_q[16][$];
   int          a_cnt[2];
   int          b_cnt[16];
   logic [1:0]  a_acc;
   logic [15:0] b_acc;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic sweep_drive(input bit gen);
      for (int i = 0; i < 2; i++) begin
         if (a_acc[i] || !a_valid[i]) begin
            if (a_acc[i]) a_cnt[i]++;
            a_valid[i]           = gen && ($urandom_range(0, 2) != 0);
            a_data[i*32 +: 32]   = (32'(i) << 24) | 32'(a_cnt[i]);
         end
      end
      for (int i = 0; i < 16; i++) begin
         if (b_acc[i] || !b_valid[i]) begin
            if (b_acc[i]) b_cnt[i]++;
            b_valid[i] = gen && ($urandom_range(0, 2) != 0);
            b_data[i]  = b_cnt[i][0];
         end
      end
      a_oready = !gen || ($urandom_range(0, 3) != 0);
      b_oready = !gen || ($urandom_range(0, 3) != 0);
   endtask

   task automatic sweep_sample();
      if (a_ovalid && a_oready) begin
         if (a_q[a_och].size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL n2_extra: got ch %0d data %0h, expected no word", a_och, a_odata);
         end else check("n2_data", 64'(a_odata), 64'(a_q[a_och].pop_front()));
      end
      if (b_ovalid && b_oready) begin
         if (b_q[b_och].size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL n16_extra: got ch %0d data %0h, expected no word", b_och, b_odata);
         end else check("n16_data", 64'(b_odata), 64'(b_q[b_och].pop_front()));
      end
      check("n2_ready", {62'd0, ($countones(a_ready) <= 1), ((a_ready & ~a_valid) == 2'd0)}, 64'd3);
      check("n16_ready", {62'd0, ($countones(b_ready) <= 1), ((b_ready & ~b_valid) == 16'd0)}, 64'd3);
      a_acc = a_valid & a_ready;
      b_acc = b_valid & b_ready;
      for (int i = 0; i < 2; i++)  if (a_acc[i]) a_q[i].push_back(a_data[i*32 +: 32]);
      for (int i = 0; i < 16; i++) if (b_acc[i]) b_q[i].push_back(b_data[i]);
   endtask

   initial begin
      // Rows: valid, out_ready, expected in_ready, out_valid, out_data, out_ch
      vecs[0]  = '{4'hF, 1'b1, 4'h1, 1'b0, 8'h00, 2'd0};
      vecs[1]  = '{4'hF, 1'b1, 4'h2, 1'b1, 8'hA0, 2'd0};
      vecs[2]  = '{4'hF, 1'b1, 4'h4, 1'b1, 8'hA1, 2'd1};
      vecs[3]  = '{4'hF, 1'b1, 4'h8, 1'b1, 8'hA2, 2'd2};
      vecs[4]  = '{4'hF, 1'b1, 4'h1, 1'b1, 8'hA3, 2'd3};
      vecs[5]  = '{4'hF, 1'b1, 4'h2, 1'b1, 8'hA0, 2'd0};
      vecs[6]  = '{4'hF, 1'b1, 4'h4, 1'b1, 8'hA1, 2'd1};
      vecs[7]  = '{4'hF, 1'b1, 4'h8, 1'b1, 8'hA2, 2'd2};
      vecs[8]  = '{4'h0, 1'b1, 4'h0, 1'b1, 8'hA3, 2'd3};
      vecs[9]  = '{4'h0, 1'b1, 4'h0, 1'b0, 8'hA3, 2'd3};
      vecs[10] = '{4'hA, 1'b1, 4'h2, 1'b0, 8'hA3, 2'd3};
      vecs[11] = '{4'hA, 1'b1, 4'h8, 1'b1, 8'hA1, 2'd1};
      vecs[12] = '{4'hA, 1'b1, 4'h2, 1'b1, 8'hA3, 2'd3};
      vecs[13] = '{4'h0, 1'b1, 4'h0, 1'b1, 8'hA1, 2'd1};
      vecs[14] = '{4'h0, 1'b1, 4'h0, 1'b0, 8'hA1, 2'd1};
      vecs[15] = '{4'h5, 1'b0, 4'h4, 1'b0, 8'hA1, 2'd1};
      vecs[16] = '{4'h5, 1'b0, 4'h0, 1'b1, 8'hA2, 2'd2};
      vecs[17] = '{4'h5, 1'b0, 4'h0, 1'b1, 8'hA2, 2'd2};
      vecs[18] = '{4'h5, 1'b0, 4'h0, 1'b1, 8'hA2, 2'd2};
      vecs[19] = '{4'h5, 1'b0, 4'h0, 1'b1, 8'hA2, 2'd2};
      vecs[20] = '{4'h5, 1'b1, 4'h1, 1'b1, 8'hA2, 2'd2};
      vecs[21] = '{4'h5, 1'b1, 4'h4, 1'b1, 8'hA0, 2'd0};
      vecs[22] = '{4'h0, 1'b1, 4'h0, 1'b1, 8'hA2, 2'd2};
      vecs[23] = '{4'h0, 1'b1, 4'h0, 1'b0, 8'hA2, 2'd2};

      rst_n   = 1'b0;
      rr_data = 32'hA3A2A1A0; rr_valid = '0; rr_sel = '0; rr_oready = 1'b1;
      fx_data = 32'h335C2211; fx_valid = '0; fx_sel = '0; fx_oready = 1'b1;
      a_data = '0; a_valid = '0; a_sel = '0; a_oready = 1'b1;
      b_data = '0; b_valid = '0; b_sel = '0; b_oready = 1'b1;
      a_acc = '0; b_acc = '0;
      for (int i = 0; i < 2; i++)  a_cnt[i] = 0;
      for (int i = 0; i < 16; i++) b_cnt[i] = 0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      next_cycle();

      // Round-robin order, sparse requests, backpressure
      for (int k = 0; k < 24; k++) begin
         rr_valid  = vecs[k].valid;
         rr_oready = vecs[k].oready;
         @(negedge clk);
         check($sformatf("v%0d_in_ready", k), 64'(rr_ready), 64'(vecs[k].exp_ready));
         check($sformatf("v%0d_out_valid", k), 64'(rr_ovalid), 64'(vecs[k].exp_ovalid));
         check($sformatf("v%0d_out_data", k), 64'(rr_odata), 64'(vecs[k].exp_odata));
         check($sformatf("v%0d_out_ch", k), 64'(rr_och), 64'(vecs[k].exp_och));
         next_cycle();
      end
      rr_valid = '0;

      // Fixed select
      fx_sel = 2'd2; fx_valid = 4'b0101;
      @(negedge clk);
      check("fx_ready_sel2", 64'(fx_ready), 64'h4);
      check("fx_ovalid_idle", 64'(fx_ovalid), 64'h0);
      next_cycle();
      @(negedge clk);
      check("fx_data_sel2", 64'(fx_odata), 64'h5C);
      check("fx_ch_sel2", 64'(fx_och), 64'h2);
      check("fx_ovalid_sel2", 64'(fx_ovalid), 64'h1);
      check("fx_ready_hold", 64'(fx_ready), 64'h4);
      next_cycle();
      fx_valid = 4'b0001;
      @(negedge clk);
      check("fx_ready_novalid", 64'(fx_ready), 64'h0);
      next_cycle();
      @(negedge clk);
      check("fx_ovalid_drain", 64'(fx_ovalid), 64'h0);
      check("fx_data_held", 64'(fx_odata), 64'h5C);
      check("fx_ch_held", 64'(fx_och), 64'h2);
      fx_sel = 2'd0;
      #1;
      check("fx_ready_sel0", 64'(fx_ready), 64'h1);
      next_cycle();
      @(negedge clk);
      check("fx_data_sel0", 64'(fx_odata), 64'h11);
      check("fx_ch_sel0", 64'(fx_och), 64'h0);
      fx_valid = '0;
      next_cycle();

      // Reset asserted while a word is held under backpressure
      rr_valid = 4'hF; rr_oready = 1'b0;
      next_cycle();
      next_cycle();
      @(negedge clk);
      check("rst_pre_ovalid", 64'(rr_ovalid), 64'h1);
      #2 rst_n = 1'b0;
      #1;
      check("rst_ovalid", 64'(rr_ovalid), 64'h0);
      check("rst_odata", 64'(rr_odata), 64'h0);
      check("rst_och", 64'(rr_och), 64'h0);
      check("rst_in_ready", 64'(rr_ready), 64'h1);
      rr_oready = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      next_cycle();
      @(negedge clk);
      check("rst_first_data", 64'(rr_odata), 64'hA0);
      check("rst_first_ch", 64'(rr_och), 64'h0);
      check("rst_first_ovalid", 64'(rr_ovalid), 64'h1);
      rr_valid = '0;
      next_cycle();

      // Randomised sweep on N=2/WIDTH=32 and N=16/WIDTH=1, then drain
      for (int cyc = 0; cyc < 3000; cyc++) begin
         sweep_drive(cyc < 2950);
         @(negedge clk);
         sweep_sample();
         next_cycle();
      end
      begin
         int a_left = 0;
         int b_left = 0;
         for (int i = 0; i < 2; i++)  a_left += a_q[i].size();
         for (int i = 0; i < 16; i++) b_left += b_q[i].size();
         check("n2_leftover", 64'(a_left), 64'd0);
         check("n16_leftover", 64'(b_left), 64'd0);
         check("n2_valid_idle", 64'(a_valid), 64'd0);
         check("n16_valid_idle", 64'(b_valid), 64'd0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/stream_mux_rr.md
# stream_mux_rr

Parametrised N-channel, WIDTH-bit stream multiplexer with valid/ready handshakes. It replaces the fixed 2:1, 8-bit combinational select path where sources are streamed rather than static. A registered output stage gives one cycle of latency and full throughput. Channel selection is either fixed, driven by an external select, or round-robin arbitrated.

## Interface
Parameters:
- WIDTH, 8: data width per channel, ≥1.
- N, 4: number of input channels, 2..16. SW = max(1, $clog2(N)).
- MODE, 0: 0 = fixed select (sel port chooses the channel); 1 = round-robin arbitration (sel ignored).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_data  in  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  in  N  per-channel valid.
- in_ready  out  N  per-channel ready; combinational.
- sel  in  SW  channel select, used in MODE 0 only.
- out_data  out  WIDTH  registered output data.
- out_valid  out  1  registered output valid.
- out_ch  out  SW  index of the channel that supplied out_data; registered.
- out_ready  in  1  downstream ready.

## Operation
- Output register: holds one word. It can load when `load_ok = !out_valid || out_ready`.
- Grant is combinational. At most one channel is granted per cycle.
  - MODE 0:
    - Grant = sel when `in_valid[sel]`; otherwise no grant.
    - A sel value ≥ N gives no grant.
  - MODE 1:
    - Scan channels starting at `(ptr+1) mod N` and wrapping.
    - The first channel with a valid is granted.
- `in_ready[i] = load_ok && (grant == i)`.
  - A non-granted channel sees in_ready=0 and must hold its data and valid.
- Transfer on channel g occurs when `in_valid[g] && in_ready[g]`. On transfer:
  - out_data <= in_data[g]
  - out_ch <= g
  - out_valid <= 1
  - in MODE 1 only, ptr <= g
- Output drain: when `out_valid && out_ready` and no new transfer occurs, out_valid <= 0.
  - out_data and out_ch then hold their last values.
- Simultaneous drain and load in the same cycle: the register loads the new word and out_valid stays 1. There is no bubble.
- ptr changes only on a transfer. Valids that are pending but not granted do not move ptr.
- Fairness: with all N channels continuously valid and out_ready=1, grants cycle 0,1,…,N-1,0,…
- Reset (asynchronous assert; release synchronous to clk):
  - out_valid=0, out_data=0, out_ch=0.
  - ptr=N-1, so channel 0 is first priority.
  - in_ready follows its combinational equation, so it is 1 for the granted channel immediately after reset.
- Reset mid-operation: the word held in the output register is discarded. No partial state survives.

## Timing
- Latency: input transfer at edge k gives out_valid=1 with that data after edge k, visible in cycle k+1.
- Throughput: 1 word/cycle while out_ready=1.
- Backpressure: out_ready=0 with out_valid=1 forces all in_ready to 0 in the same cycle.
  - out_data, out_ch and out_valid stay stable until accepted.
- Combinational paths:
  - in_valid/sel → in_ready
  - out_ready → in_ready
- No combinational path from any input to out_data, out_valid or out_ch.

## Test plan
1. **Reset state.** MODE 1, N=4, WIDTH=8. Assert rst_n=0 mid-stream with out_valid=1.
   - Required: out_valid=0, out_data=0x00 and out_ch=0 immediately.
   - Required: after release, the first grant goes to channel 0 when all channels are valid.
2. **Round-robin order.** MODE 1, all 4 channels valid with data 0xA0+i, out_ready=1 for 8 cycles.
   - Required out_ch sequence: 0,1,2,3,0,1,2,3.
   - Required out_data sequence: 0xA0,0xA1,0xA2,0xA3,…
3. **Sparse requests.** MODE 1. Only channels 1 and 3 valid after ptr=3.
   - Required: grant 1, then 3, then 1.
   - Required: channels 0 and 2 never get in_ready=1.
4. **Fixed select.** MODE 0, sel=2, in_data[2]=0x5C valid, channel 0 also valid.
   - Required: out_data=0x5C, out_ch=2.
   - Required: in_ready[0]=0 throughout.
   - With sel=2 and in_valid[2]=0: no transfer and out_valid drains to 0.
5. **Backpressure.** MODE 1. Hold out_ready=0 for 5 cycles while 2 channels are valid.
   - Required: out_data is stable, and all in_ready are 0 after the first load.
   - Required: on release, the next transfer happens in the same cycle as the drain, with no bubble.
6. **Parameter sweep.** N=2 and N=16, WIDTH=1 and WIDTH=32, randomised valid/ready with a scoreboard.
   - Required: every accepted word appears once, in per-channel order, with the correct out_ch.
